// File: rtl/period_meter.sv
// period_meter
// Measures the period and high time of an asynchronous input (sig_in) in
// clk_100MHz cycles. sig_in is synchronized and edge-detected, then a
// three-state FSM counts cycles between consecutive rising edges. Results are
// published with a one-cycle meas_valid pulse. A sticky timeout flag is raised
// when no rising edge arrives within TIMEOUT cycles.
module period_meter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 200_000_000
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    // Last count value before a measurement is abandoned.
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 32'd1);

    state_t           state_r;
    logic             s1_r;
    logic             s2_r;
    logic             s3_r;
    logic             rise_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] hcnt_r;

    // Two-flop synchronizer for sig_in followed by a history flop for edge detection
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= sig_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Synchronized rising edge of sig_in
    assign rise_s = s2_r & ~s3_r;

    // Measurement FSM: counters, timeout handling and registered result outputs
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            hcnt_r     <= CNT_ZERO;
            period_out <= CNT_ZERO;
            high_out   <= CNT_ZERO;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            // meas_valid is a single-cycle pulse unless a result is published below
            meas_valid <= 1'b0;
            if (!enable) begin
                // Abort: results and timeout flag hold, measurement in progress dropped
                state_r <= IDLE;
                cnt_r   <= CNT_ZERO;
                hcnt_r  <= CNT_ZERO;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= ARMED;
                        cnt_r   <= CNT_ZERO;
                        hcnt_r  <= CNT_ZERO;
                    end
                    ARMED: begin
                        if (rise_s) begin
                            // First edge only starts the measurement window
                            state_r <= MEASURE;
                            cnt_r   <= CNT_ONE;
                            hcnt_r  <= CNT_ONE;
                        end else if (cnt_r == CNT_LAST) begin
                            timeout <= 1'b1;
                            cnt_r   <= CNT_ZERO;
                            hcnt_r  <= CNT_ZERO;
                        end else begin
                            // Count while waiting so a missing first edge also times out
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    MEASURE: begin
                        if (rise_s) begin
                            // Rise wins over a coincident timeout
                            period_out <= cnt_r;
                            high_out   <= hcnt_r;
                            meas_valid <= 1'b1;
                            timeout    <= 1'b0;
                            cnt_r      <= CNT_ONE;
                            hcnt_r     <= CNT_ONE;
                        end else if (cnt_r == CNT_LAST) begin
                            timeout <= 1'b1;
                            state_r <= ARMED;
                            cnt_r   <= CNT_ZERO;
                            hcnt_r  <= CNT_ZERO;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                            if (s2_r) begin
                                hcnt_r <= hcnt_r + CNT_ONE;
                            end else begin
                                hcnt_r <= hcnt_r;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                        hcnt_r  <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter: directed and randomized sig_in waveforms checked
// against an edge-index based reference model of the measurement rules.
module tb_period_meter;

    localparam int W  = 16;
    localparam int TO = 16;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_MEAS  = 2;

    logic         clk_100MHz = 1'b0;
    logic         reset      = 1'b1;
    logic         enable     = 1'b0;
    logic         sig_in     = 1'b0;
    logic [W-1:0] period_out;
    logic [W-1:0] high_out;
    logic         meas_valid;
    logic         timeout;

    int errors = 0;
    int checks = 0;

    period_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .enable     (enable),
        .sig_in     (sig_in),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .timeout    (timeout)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // ---------------- reference model ----------------
    // Every sampled sig_in value is stored by edge index (edge 0 = first edge
    // after reset release). The synchronized level seen at edge m is the input
    // sampled two edges earlier; a rise is a 0->1 step of that delayed level.
    // anchor is the edge at which the running count was zero (armed) or one
    // (after a rise): in both cases the count at edge m equals m - anchor.
    bit           samp [0:4095];
    int           md_n;
    int           md_mode;
    int           md_anchor;
    int           md_m;
    int           md_hsum;
    bit           md_rise;
    logic         m_mv;
    logic         m_to;
    logic [W-1:0] m_per;
    logic [W-1:0] m_high;

    function automatic bit samp_at(int i);
        if (i < 0 || i > 4095) return 1'b0;
        return samp[i];
    endfunction

    always @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            md_n = 0; md_mode = M_IDLE; md_anchor = 0;
            m_mv = 1'b0; m_to = 1'b0; m_per = '0; m_high = '0;
        end else begin
            md_m = md_n;
            if (md_m <= 4095) samp[md_m] = sig_in;
            md_n = md_n + 1;
            md_rise = samp_at(md_m - 2) && !samp_at(md_m - 3);
            m_mv = 1'b0;
            if (!enable) begin
                md_mode = M_IDLE;
            end else if (md_mode == M_IDLE) begin
                md_mode = M_ARMED;
                md_anchor = md_m + 1;
            end else if (md_rise) begin
                if (md_mode == M_MEAS) begin
                    md_hsum = 0;
                    for (int j = md_anchor; j < md_m; j++) md_hsum += int'(samp_at(j - 2));
                    m_per  = W'(md_m - md_anchor);
                    m_high = W'(md_hsum);
                    m_mv   = 1'b1;
                    m_to   = 1'b0;
                end
                md_mode = M_MEAS;
                md_anchor = md_m;
            end else if (md_m - md_anchor == TO - 1) begin
                m_to = 1'b1;
                md_mode = M_ARMED;
                md_anchor = md_m + 1;
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_reset();
        @(negedge clk_100MHz);
        reset = 1'b1; enable = 1'b0; sig_in = 1'b0;
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; sig_in = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        checks++;
        if ({period_out, high_out, meas_valid, timeout} !== {(2*W+2){1'b0}}) begin
            errors++;
            $display("FAIL reset: got per=%0d hi=%0d mv=%b to=%b, want all 0",
                     period_out, high_out, meas_valid, timeout);
        end
        reset = 1'b0;
    endtask

    task automatic test_period8();
        int pulses = 0;
        do_reset();
        enable = 1'b1;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk_100MHz);
            checks++;
            if ({meas_valid, timeout, period_out, high_out} !== {m_mv, m_to, m_per, m_high}) begin
                errors++;
                $display("FAIL period8 t=%0d: got mv=%b to=%b per=%0d hi=%0d, want mv=%b to=%b per=%0d hi=%0d",
                         t, meas_valid, timeout, period_out, high_out, m_mv, m_to, m_per, m_high);
            end
            if (meas_valid === 1'b1) begin
                pulses++;
                checks++;
                if (period_out !== 16'd8 || high_out !== 16'd4) begin
                    errors++;
                    $display("FAIL period8_value: got per=%0d hi=%0d, want per=8 hi=4", period_out, high_out);
                end
            end
            sig_in = ((t % 8) < 4);
        end
        checks++;
        if (pulses < 8) begin
            errors++;
            $display("FAIL period8_count: got %0d pulses, want at least 8", pulses);
        end
    endtask

    task automatic test_duty3of10();
        int pulses = 0;
        do_reset();
        enable = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk_100MHz);
            checks++;
            if ({meas_valid, timeout, period_out, high_out} !== {m_mv, m_to, m_per, m_high}) begin
                errors++;
                $display("FAIL duty3of10 t=%0d: got mv=%b to=%b per=%0d hi=%0d, want mv=%b to=%b per=%0d hi=%0d",
                         t, meas_valid, timeout, period_out, high_out, m_mv, m_to, m_per, m_high);
            end
            if (meas_valid === 1'b1) begin
                pulses++;
                checks++;
                if (period_out !== 16'd10 || high_out !== 16'd3) begin
                    errors++;
                    $display("FAIL duty3of10_value: got per=%0d hi=%0d, want per=10 hi=3", period_out, high_out);
                end
            end
            sig_in = ((t % 10) < 3);
        end
        checks++;
        if (pulses < 4) begin
            errors++;
            $display("FAIL duty3of10_count: got %0d pulses, want at least 4", pulses);
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        do_reset();
        enable = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk_100MHz);
            checks++;
            if ({meas_valid, timeout, period_out, high_out} !== {m_mv, m_to, m_per, m_high}) begin
                errors++;
                $display("FAIL timeout_idle t=%0d: got mv=%b to=%b per=%0d hi=%0d, want mv=%b to=%b per=%0d hi=%0d",
                         t, meas_valid, timeout, period_out, high_out, m_mv, m_to, m_per, m_high);
            end
            if (meas_valid === 1'b1) pulses++;
            sig_in = 1'b0;
        end
        checks++;
        if (timeout !== 1'b1 || pulses != 0) begin
            errors++;
            $display("FAIL timeout_set: got to=%b pulses=%0d, want to=1 pulses=0", timeout, pulses);
        end
        for (int t = 0; t < 25; t++) begin
            @(negedge clk_100MHz);
            checks++;
            if ({meas_valid, timeout, period_out, high_out} !== {m_mv, m_to, m_per, m_high}) begin
                errors++;
                $display("FAIL timeout_recover t=%0d: got mv=%b to=%b per=%0d hi=%0d, want mv=%b to=%b per=%0d hi=%0d",
                         t, meas_valid, timeout, period_out, high_out, m_mv, m_to, m_per, m_high);
            end
            sig_in = ((t % 10) < 3);
        end
        checks++;
        if (timeout !== 1'b0 || period_out !== 16'd10) begin
            errors++;
            $display("FAIL timeout_clear: got to=%b per=%0d, want to=0 per=10", timeout, period_out);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk_100MHz);
            checks++;
            if ({meas_valid, timeout, period_out, high_out} !== {m_mv, m_to, m_per, m_high}) begin
                errors++;
                $display("FAIL enable_drop t=%0d: got mv=%b to=%b per=%0d hi=%0d, want mv=%b to=%b per=%0d hi=%0d",
                         t, meas_valid, timeout, period_out, high_out, m_mv, m_to, m_per, m_high);
            end
            if (t >= 31 && t <= 58) begin
                checks++;
                if (meas_valid !== 1'b0 || period_out !== 16'd8 || high_out !== 16'd4 || timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL enable_hold t=%0d: got mv=%b per=%0d hi=%0d to=%b, want mv=0 per=8 hi=4 to=0",
                             t, meas_valid, period_out, high_out, timeout);
                end
            end
            sig_in = ((t % 8) < 4);
            enable = !(t >= 30 && t < 42);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk_100MHz);
            checks++;
            if ({meas_valid, timeout, period_out, high_out} !== {m_mv, m_to, m_per, m_high}) begin
                errors++;
                $display("FAIL async_pre t=%0d: got mv=%b to=%b per=%0d hi=%0d, want mv=%b to=%b per=%0d hi=%0d",
                         t, meas_valid, timeout, period_out, high_out, m_mv, m_to, m_per, m_high);
            end
            sig_in = ((t % 8) < 4);
        end
        @(posedge clk_100MHz);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({period_out, high_out, meas_valid, timeout} !== {(2*W+2){1'b0}}) begin
            errors++;
            $display("FAIL async_reset: got per=%0d hi=%0d mv=%b to=%b, want all 0",
                     period_out, high_out, meas_valid, timeout);
        end
        @(negedge clk_100MHz);
        reset = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        do_reset();
        enable = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk_100MHz);
            checks++;
            if ({meas_valid, timeout, period_out, high_out} !== {m_mv, m_to, m_per, m_high}) begin
                errors++;
                $display("FAIL back_to_back t=%0d: got mv=%b to=%b per=%0d hi=%0d, want mv=%b to=%b per=%0d hi=%0d",
                         t, meas_valid, timeout, period_out, high_out, m_mv, m_to, m_per, m_high);
            end
            if (meas_valid === 1'b1) begin
                pulses++;
                checks++;
                if (period_out !== 16'd2 || high_out !== 16'd1) begin
                    errors++;
                    $display("FAIL back_to_back_value: got per=%0d hi=%0d, want per=2 hi=1", period_out, high_out);
                end
            end
            sig_in = ((t % 2) == 0);
        end
        checks++;
        if (pulses < 10) begin
            errors++;
            $display("FAIL back_to_back_count: got %0d pulses, want at least 10", pulses);
        end
    endtask

    task automatic test_boundary();
        int pulses = 0;
        do_reset();
        enable = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk_100MHz);
            checks++;
            if ({meas_valid, timeout, period_out, high_out} !== {m_mv, m_to, m_per, m_high}) begin
                errors++;
                $display("FAIL boundary15 t=%0d: got mv=%b to=%b per=%0d hi=%0d, want mv=%b to=%b per=%0d hi=%0d",
                         t, meas_valid, timeout, period_out, high_out, m_mv, m_to, m_per, m_high);
            end
            if (meas_valid === 1'b1) begin
                pulses++;
                checks++;
                if (period_out !== 16'd15 || high_out !== 16'd1 || timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL boundary15_value: got per=%0d hi=%0d to=%b, want per=15 hi=1 to=0",
                             period_out, high_out, timeout);
                end
            end
            sig_in = ((t % 15) == 0);
        end
        checks++;
        if (pulses < 2) begin
            errors++;
            $display("FAIL boundary15_count: got %0d pulses, want at least 2", pulses);
        end
        pulses = 0;
        for (int t = 0; t < 70; t++) begin
            @(negedge clk_100MHz);
            checks++;
            if ({meas_valid, timeout, period_out, high_out} !== {m_mv, m_to, m_per, m_high}) begin
                errors++;
                $display("FAIL boundary16 t=%0d: got mv=%b to=%b per=%0d hi=%0d, want mv=%b to=%b per=%0d hi=%0d",
                         t, meas_valid, timeout, period_out, high_out, m_mv, m_to, m_per, m_high);
            end
            if (t >= 20 && meas_valid === 1'b1) pulses++;
            sig_in = ((t % 16) == 0);
        end
        checks++;
        if (pulses != 0 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL boundary16: got pulses=%0d to=%b, want pulses=0 to=1", pulses, timeout);
        end
    endtask

    task automatic test_random();
        int hi;
        int lo;
        do_reset();
        enable = 1'b1;
        for (int seg = 0; seg < 60; seg++) begin
            hi = $urandom_range(1, 8);
            lo = $urandom_range(1, 9);
            for (int c = 0; c < hi + lo; c++) begin
                @(negedge clk_100MHz);
                checks++;
                if ({meas_valid, timeout, period_out, high_out} !== {m_mv, m_to, m_per, m_high}) begin
                    errors++;
                    $display("FAIL random seg=%0d c=%0d: got mv=%b to=%b per=%0d hi=%0d, want mv=%b to=%b per=%0d hi=%0d",
                             seg, c, meas_valid, timeout, period_out, high_out, m_mv, m_to, m_per, m_high);
                end
                sig_in = (c < hi);
                if (c == 0) enable = ($urandom_range(0, 7) != 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_period8();
        test_duty3of10();
        test_timeout();
        test_enable_drop();
        test_async_reset();
        test_back_to_back();
        test_boundary();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
